// File: rtl/seq_mem_if.sv
// Bundle of the seq_mem control and status signals between the controller and the sequence store.
interface seq_mem_if #(
  parameter int PTR_W = 5
);
  logic             clr;
  logic             append;
  logic [1:0]       append_data;
  logic             rd_start;
  logic             rd_next;
  logic             cmp_valid;
  logic [1:0]       cmp_data;
  logic [1:0]       rd_data;
  logic             rd_last;
  logic [PTR_W:0]   len;
  logic             full;
  logic             match;
  logic             mismatch;
  logic             done;
  logic [PTR_W:0]   hiscore;

  modport master (
    output clr, append, append_data, rd_start, rd_next, cmp_valid, cmp_data,
    input  rd_data, rd_last, len, full, match, mismatch, done, hiscore
  );

  modport slave (
    input  clr, append, append_data, rd_start, rd_next, cmp_valid, cmp_data,
    output rd_data, rd_last, len, full, match, mismatch, done, hiscore
  );
endinterface

// File: rtl/seq_mem.sv
// Simon move-sequence store: append, playback and per-move compare of 2-bit moves.
// Optional high-score tracking is enabled with the SEQ_MEM_HISCORE_EN macro.
module seq_mem #(
  parameter int DEPTH = 32,
  parameter int PTR_W = 5
) (
  input  logic     clk_i,
  input  logic     rst_n_i,
  seq_mem_if.slave bus
);
  localparam logic [PTR_W:0] DepthC = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] OneC   = (PTR_W+1)'(1);

  logic [1:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] rp_q, rp_d;
  logic [PTR_W:0]   len_q, len_d;
  logic             match_q, match_d;
  logic             mismatch_q, mismatch_d;
  logic             done_q, done_d;
  logic             we_s, empty_s, full_s, last_s;
  logic [1:0]       cur_s;

  assign empty_s = (len_q == '0);
  assign full_s  = (len_q == DepthC);
  assign last_s  = !empty_s && ({1'b0, rp_q} == (len_q - OneC));
  assign cur_s   = mem_q[rp_q];
  assign we_s    = !bus.clr && bus.append && !full_s;

  // Next-state for length, read pointer and compare pulses.
  always_comb begin
    len_d      = len_q;
    rp_d       = rp_q;
    match_d    = 1'b0;
    mismatch_d = 1'b0;
    done_d     = 1'b0;
    if (bus.clr) begin
      len_d = '0;
      rp_d  = '0;
    end else begin
      if (we_s) begin
        len_d = len_q + OneC;
      end else begin
        len_d = len_q;
      end
      // Read side decisions use the pre-edge length, so a same-cycle append cannot move RD_LAST.
      if (bus.rd_start) begin
        rp_d = '0;
      end else if (bus.rd_next) begin
        if (!empty_s && !last_s) begin
          rp_d = rp_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
          rp_d = rp_q;
        end
      end else if (bus.cmp_valid) begin
        if (empty_s) begin
          mismatch_d = 1'b1;
        end else if (bus.cmp_data == cur_s) begin
          match_d = 1'b1;
          if (last_s) begin
            done_d = 1'b1;
          end else begin
            rp_d = rp_q + {{(PTR_W-1){1'b0}}, 1'b1};
          end
        end else begin
          mismatch_d = 1'b1;
        end
      end else begin
        rp_d = rp_q;
      end
    end
  end

  // State and pulse registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      len_q      <= '0;
      rp_q       <= '0;
      match_q    <= 1'b0;
      mismatch_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      len_q      <= len_d;
      rp_q       <= rp_d;
      match_q    <= match_d;
      mismatch_q <= mismatch_d;
      done_q     <= done_d;
    end
  end

  // Move storage; CLR leaves contents in place.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 2'b00;
      end
    end else if (we_s) begin
      mem_q[len_q[PTR_W-1:0]] <= bus.append_data;
    end
  end

`ifdef SEQ_MEM_HISCORE_EN
  logic [PTR_W:0] hiscore_q, hiscore_d;

  // High score follows the largest length reached since reset.
  always_comb begin
    if (we_s && ((len_q + OneC) > hiscore_q)) begin
      hiscore_d = len_q + OneC;
    end else begin
      hiscore_d = hiscore_q;
    end
  end

  // High-score register, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hiscore_q <= '0;
    end else begin
      hiscore_q <= hiscore_d;
    end
  end

  assign bus.hiscore = hiscore_q;
`else
  assign bus.hiscore = '0;
`endif

  assign bus.rd_data  = empty_s ? 2'b00 : cur_s;
  assign bus.rd_last  = last_s;
  assign bus.len      = len_q;
  assign bus.full     = full_s;
  assign bus.match    = match_q;
  assign bus.mismatch = mismatch_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_seq_mem.sv
// Randomised bench for seq_mem against a queue-based model of the move sequence.
module tb_seq_mem;
  localparam int DEPTH = 32;
  localparam int PTR_W = 5;

  logic clk;
  logic rst_n;

  seq_mem_if #(.PTR_W(PTR_W)) bus ();

  seq_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: the game sequence as a queue, a playback index and the best length seen.
  int seq[$];
  int rp_m;
  int hi_m;
  int em, emm, ed;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    seq.delete();
    rp_m = 0; hi_m = 0; em = 0; emm = 0; ed = 0;
  endtask

  task automatic check_all(input string tag);
    int n;
    n = seq.size();
    chk({tag, ".len"},      32'(bus.len),      n);
    chk({tag, ".full"},     32'(bus.full),     (n == DEPTH) ? 1 : 0);
    chk({tag, ".rd_last"},  32'(bus.rd_last),  (n > 0 && rp_m == n - 1) ? 1 : 0);
    chk({tag, ".rd_data"},  32'(bus.rd_data),  (n > 0) ? seq[rp_m] : 0);
    chk({tag, ".match"},    32'(bus.match),    em);
    chk({tag, ".mismatch"}, 32'(bus.mismatch), emm);
    chk({tag, ".done"},     32'(bus.done),     ed);
`ifdef SEQ_MEM_HISCORE_EN
    chk({tag, ".hiscore"},  32'(bus.hiscore),  hi_m);
`else
    chk({tag, ".hiscore"},  32'(bus.hiscore),  0);
`endif
  endtask

  task automatic idle();
    bus.clr = 1'b0; bus.append = 1'b0; bus.append_data = 2'b00;
    bus.rd_start = 1'b0; bus.rd_next = 1'b0; bus.cmp_valid = 1'b0; bus.cmp_data = 2'b00;
  endtask

  task automatic cyc(input bit clr, input bit app, input int ad, input bit rs,
                     input bit rn, input bit cv, input int cd);
    int n;
    bit last;
    bus.clr = clr; bus.append = app; bus.append_data = 2'(ad);
    bus.rd_start = rs; bus.rd_next = rn; bus.cmp_valid = cv; bus.cmp_data = 2'(cd);
    @(posedge clk);
    #1;
    em = 0; emm = 0; ed = 0;
    if (clr) begin
      seq.delete();
      rp_m = 0;
    end else begin
      n = seq.size();
      last = (n > 0) && (rp_m == n - 1);
      if (rs) rp_m = 0;
      else if (rn) begin
        if (n > 0 && !last) rp_m++;
      end else if (cv) begin
        if (n == 0) emm = 1;
        else if (cd == seq[rp_m]) begin
          em = 1;
          if (last) ed = 1; else rp_m++;
        end else emm = 1;
      end
      if (app && n < DEPTH) begin
        seq.push_back(ad);
        if (seq.size() > hi_m) hi_m = seq.size();
      end
    end
    check_all("cyc");
    idle();
  endtask

  task automatic do_app(input int d); cyc(0, 1, d, 0, 0, 0, 0); endtask
  task automatic do_cmp(input int d); cyc(0, 0, 0, 0, 0, 1, d); endtask
  task automatic do_start(); cyc(0, 0, 0, 1, 0, 0, 0); endtask
  task automatic do_next();  cyc(0, 0, 0, 0, 1, 0, 0); endtask
  task automatic do_clr();   cyc(1, 0, 0, 0, 0, 0, 0); endtask

  // Asynchronous reset issued between clock edges.
  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int cd;
    idle();
    model_reset();
    rst_n = 1'b0;
    #12;
    check_all("reset");
    rst_n = 1'b1;

    do_cmp(2);
    chk("empty_mismatch", 32'(bus.mismatch), 1);
    chk("empty_len", 32'(bus.len), 0);

    do_app(3); do_app(0); do_app(2);
    do_start(); chk("play0", 32'(bus.rd_data), 3);
    do_next();  chk("play1", 32'(bus.rd_data), 0);
    do_next();  chk("play2", 32'(bus.rd_data), 2); chk("play2_last", 32'(bus.rd_last), 1);
    do_next();  chk("play3", 32'(bus.rd_data), 2); chk("play3_last", 32'(bus.rd_last), 1);
    chk("play_len", 32'(bus.len), 3);

    do_clr(); do_app(1); do_app(2); do_start();
    do_cmp(1); chk("pass1_match", 32'(bus.match), 1); chk("pass1_done", 32'(bus.done), 0);
    do_cmp(2); chk("pass2_match", 32'(bus.match), 1); chk("pass2_done", 32'(bus.done), 1);

    do_start();
    do_cmp(3); chk("fail_mismatch", 32'(bus.mismatch), 1); chk("fail_rd", 32'(bus.rd_data), 1);
    do_cmp(1); chk("fail_then_match", 32'(bus.match), 1);

    do_clr();
    for (int i = 0; i < DEPTH; i++) do_app($urandom_range(0, 3));
    cd = seq[DEPTH-1];
    do_app(3 - cd); do_app(3 - cd);
    chk("full_len", 32'(bus.len), DEPTH);
    chk("full_flag", 32'(bus.full), 1);
    do_start();
    for (int i = 0; i < DEPTH - 1; i++) do_next();
    chk("full_tail", 32'(bus.rd_data), cd);

    async_reset();
    for (int i = 0; i < 5; i++) do_app($urandom_range(0, 3));
    do_clr(); do_app(1); do_app(0);
    chk("clr_len", 32'(bus.len), 2);
`ifdef SEQ_MEM_HISCORE_EN
    chk("clr_hiscore", 32'(bus.hiscore), 5);
`else
    chk("clr_hiscore", 32'(bus.hiscore), 0);
`endif

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        async_reset();
      end else begin
        if (seq.size() > 0 && $urandom_range(0, 3) != 0) cd = seq[rp_m];
        else cd = $urandom_range(0, 3);
        cyc($urandom_range(0, 99) < 2, $urandom_range(0, 2) == 0, $urandom_range(0, 3),
            $urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 1) == 0, cd);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seq_mem.md
# seq_mem

Move-sequence store for the Simon game, sitting between `rng` and `controller` in the 10 kHz domain. It appends one 2-bit random move per round, plays the stored sequence back for the lamp/oscillator path, and checks each synchronised player input against the expected move. The controller keeps only round-level state; all per-move indexing lives here.

## Interface
- `DEPTH`, 32: maximum number of stored moves; a power of two, 4–256.
- `PTR_W`, 5: pointer width, equal to log2(`DEPTH`).
- `CLK` in 1: block clock, driven by the 10 kHz divided clock.
- `RST_N` in 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `CLR` in 1: synchronous clear of the sequence for a new game.
- `APPEND` in 1: write `APPEND_DATA` into slot `LEN` and increment `LEN`.
- `APPEND_DATA` in 2: move to append, taken from `rng`.
- `RD_START` in 1: set the read pointer to 0.
- `RD_NEXT` in 1: advance the read pointer, for playback.
- `CMP_VALID` in 1: the player move on `CMP_DATA` is valid this cycle.
- `CMP_DATA` in 2: the player move, taken from `io_sync`.
- `RD_DATA` out 2: the move at the read pointer.
- `RD_LAST` out 1: the read pointer equals `LEN`-1 and `LEN` is greater than 0.
- `LEN` out `PTR_W`+1: the number of stored moves, 0..`DEPTH`.
- `FULL` out 1: `LEN` equals `DEPTH`.
- `MATCH` out 1: one-cycle pulse; the compared move was correct.
- `MISMATCH` out 1: one-cycle pulse; the compared move was wrong.
- `DONE` out 1: one-cycle pulse; the last move of the sequence was matched.
- `HISCORE` out `PTR_W`+1: the longest `LEN` reached since reset (see Configuration).

## Operation
- Storage is a `DEPTH`×2 register array, with a registered read pointer `rp` (`PTR_W` bits) and a registered `LEN`.
- `RD_DATA` is a combinational read of `mem[rp]`. It is 0 when `LEN`=0.
- **`CLR`** (highest priority):
  - `LEN` and `rp` go to 0.
  - Every pulse output is suppressed that cycle.
  - Memory is not cleared.
  - `HISCORE` is kept.
- **`APPEND`**:
  - When `FULL`=0, writes `mem[LEN]` and increments `LEN`.
  - When `FULL`=1, it is ignored; nothing changes.
  - The write port is independent of the read/compare logic, so it may coincide with any read-side operation.
- **Read-side priority:** `RD_START` > `RD_NEXT` > `CMP_VALID`. Only one of these acts per cycle.
- **`RD_NEXT`:**
  - `rp` increments.
  - At `RD_LAST`, `rp` saturates and does not wrap.
  - Ignored when `LEN`=0.
- **`CMP_VALID`:**
  - When `LEN`=0, produces `MISMATCH`.
  - When `CMP_DATA`==`mem[rp]`, produces `MATCH`. If `RD_LAST`, it also produces `DONE` and `rp` is held; otherwise `rp` increments.
  - When `CMP_DATA`!=`mem[rp]`, produces `MISMATCH` and `rp` is held.
- `MATCH` and `MISMATCH` are mutually exclusive. `DONE` implies `MATCH`.
- An `APPEND` in the same cycle as a compare at `RD_LAST` does not affect that compare. The compare uses the pre-edge `LEN`.

## Timing
- Reset values: `LEN`, `rp`, `HISCORE`, `FULL`, `RD_LAST`, `MATCH`, `MISMATCH`, `DONE` and `RD_DATA` are all 0. Memory is all 0.
- All state updates happen on the rising `CLK` edge.
- An input sampled at edge N is reflected in the outputs after edge N:
  - `LEN`, `FULL`, `RD_LAST` and `RD_DATA` follow the registered state.
  - `MATCH`, `MISMATCH` and `DONE` are registered and high for exactly the one cycle after edge N.
- An appended move is readable one cycle after its `APPEND`.
- Comparisons can be issued back-to-back, one per cycle; there are no stalls.
- Asserting `RST_N` mid-sequence immediately forces every output to its reset value, independent of `CLK`.

## Configuration
- Macro: `SEQ_MEM_HISCORE_EN`.
- Defined:
  - `HISCORE` is a register updated to `LEN`+1 on any accepted `APPEND` where `LEN`+1 > `HISCORE`.
  - `HISCORE` survives `CLR` and is reset only by `RST_N`.
- Undefined: `HISCORE` is tied to 0 and no register is inferred.

## Test plan
- **Reset/empty:**
  - Release `RST_N`, then pulse `CMP_VALID` with `CMP_DATA`=2 → `MISMATCH`=1 for one cycle, `LEN`=0, `RD_DATA`=0.
- **Append and playback:**
  - Append 3, 0, 2, then `RD_START`, then `RD_NEXT`×3 → `RD_DATA` is 3, 0, 2, 2, with `RD_LAST`=1 from the third read onward and `LEN`=3.
- **Compare pass:**
  - With stored sequence 1, 2, `RD_START`, then compare 1, 2 → `MATCH` on both cycles, `DONE` only on the second.
- **Compare fail:**
  - With stored sequence 1, 2, compare 3 → `MISMATCH` pulse and `rp` held. Then compare 1 → `MATCH`.
- **Full:**
  - Append `DEPTH`+2 moves → `LEN`=`DEPTH` and `FULL`=1; extra appends are ignored and `mem[DEPTH-1]` is unchanged.
- **`CLR` and hiscore (`SEQ_MEM_HISCORE_EN` defined):**
  - Append 5 moves, `CLR`, append 2 → `LEN`=2 and `HISCORE`=5.
  - Without the macro, `HISCORE`=0 throughout.
